// File: rtl/systolic_if.sv
// systolic_if: operand streams, host tile indices and result registers of the 2x2 systolic array.
interface systolic_if #(parameter int data_size = 8);
    logic [data_size-1:0] a1, a2, b1, b2;
    logic [4:0] i, j;
    logic [2*data_size-1:0] c1, c2, c3, c4;
    modport master (output a1, a2, b1, b2, i, j, input c1, c2, c3, c4);
    modport slave (input a1, a2, b1, b2, i, j, output c1, c2, c3, c4);
endinterface

// File: rtl/systolic_top.sv
// systolic_top: output-stationary 2x2 matrix-multiply array, one tile of K=8 products per 8-cycle window.
module systolic_top #(parameter int data_size = 8) (
    input logic clk,
    input logic reset,
    systolic_if.slave bus
);
    localparam int w = 2 * data_size;
    logic [2:0] ph_q, ph_d;
    logic [data_size-1:0] a_q [4], b_q [4], a_d [4], b_d [4];
    logic [w-1:0] acc_q [4], acc_d [4], c_q [4], c_d [4];
    logic [3:0] close;
    logic unused_fwd;
    always_comb begin
        a_d = '{bus.a1, a_q[0], bus.a2, a_q[2]};
        b_d = '{bus.b1, bus.b2, b_q[0], b_q[1]};
        ph_d = ph_q + 3'd1;
        // downstream PEs see each operand one cycle later per hop, so they close later
        close = {ph_q == 3'd1, ph_q == 3'd0, ph_q == 3'd0, ph_q == 3'd7};
    end
    for (genvar p = 0; p < 4; p++) begin : g_pe
        logic [w-1:0] sum;
        assign sum = acc_q[p] + w'(a_d[p]) * w'(b_d[p]);
        assign acc_d[p] = close[p] ? '0 : sum;
        assign c_d[p] = close[p] ? sum : c_q[p];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q <= 3'd7;
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            acc_q <= '{default: '0};
            c_q <= '{default: '0};
        end else begin
            ph_q <= ph_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            c_q <= c_d;
        end
    end
    assign bus.c1 = c_q[0];
    assign bus.c2 = c_q[1];
    assign bus.c3 = c_q[2];
    assign bus.c4 = c_q[3];
    // edge-of-array forwards and the tile indices have no consumer
    assign unused_fwd = ^{a_q[1], a_q[3], b_q[2], b_q[3], bus.i, bus.j};
endmodule

// File: tb/tb_systolic_top.sv
// tb_systolic_top: scoreboard bench for the 2x2 systolic array; the monitor tracks its own tile phase.
module tb_systolic_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    systolic_if #(.data_size(8)) bus ();
    systolic_top #(.data_size(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sq [$];
    logic [15:0] c_act [4];
    logic [7:0] ra0 [48], ra1 [48], cb0 [48], cb1 [48];
    logic [2:0] close_ph [4] = '{3'd7, 3'd0, 3'd0, 3'd1};
    logic [2:0] mon_ph = 3'd7;
    logic [2:0] mon_pre;
    logic [15:0] mon_cur [4] = '{default: '0};
    int mon_e = 0;

    always_comb c_act = '{bus.c1, bus.c2, bus.c3, bus.c4};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic push4(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input logic [15:0] v);
        sq.push_back(x);
        sq.push_back(y);
        sq.push_back(z);
        sq.push_back(v);
    endtask

    task automatic drive(input logic [7:0] x1, input logic [7:0] y1, input logic [7:0] x2, input logic [7:0] y2);
        @(negedge clk);
        bus.a1 = x1;
        bus.b1 = y1;
        bus.a2 = x2;
        bus.b2 = y2;
        bus.i = 5'($urandom_range(0, 31));
        bus.j = 5'($urandom_range(0, 31));
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            if (reset) begin
                mon_ph = 3'd7;
                mon_cur = '{default: '0};
                mon_e = 0;
            end else begin
                mon_pre = mon_ph;
                mon_ph = mon_ph + 3'd1;
                mon_e++;
                #1;
                for (int n = 0; n < 4; n++) begin
                    if (mon_pre == close_ph[n]) begin
                        if (sq.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL c%0d edge %0d: got %0d at a close, expected a queued result", n + 1, mon_e, c_act[n]);
                        end else mon_cur[n] = sq.pop_front();
                    end
                    chk($sformatf("c%0d edge %0d", n + 1, mon_e), c_act[n], mon_cur[n]);
                end
            end
        end
    end

    initial begin : driver
        bus.a1 = '0;
        bus.a2 = '0;
        bus.b1 = '0;
        bus.b2 = '0;
        bus.i = '0;
        bus.j = '0;
        // tiles: (0,0), (0,2), zeros, 255s, 255s (aborted by reset)
        for (int t = 0; t < 48; t++) begin
            ra0[t] = t / 8 == 2 ? 8'd0 : t / 8 >= 3 ? 8'd255 : 8'((t % 8 + 1) % 8);
            ra1[t] = t / 8 == 2 ? 8'd0 : t / 8 >= 3 ? 8'd255 : 8'((t % 8 + 2) % 8);
            cb0[t] = t / 8 == 0 ? 8'(t % 8) : t / 8 == 1 ? 8'((t % 8 + 2) % 8) : t / 8 == 2 ? 8'd0 : 8'd255;
            cb1[t] = t / 8 == 0 ? 8'((t % 8 + 1) % 8) : t / 8 == 1 ? 8'((t % 8 + 3) % 8) : t / 8 == 2 ? 8'd0 : 8'd255;
        end
        push4(16'd0, 16'd0, 16'd0, 16'd0);
        push4(16'd112, 16'd140, 16'd92, 16'd112);
        push4(16'd112, 16'd92, 16'd140, 16'd112);
        push4(16'd0, 16'd0, 16'd0, 16'd0);
        push4(16'd61448, 16'd61448, 16'd61448, 16'd61448);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 38; t++)
            drive(ra0[t], cb0[t], t > 0 ? ra1[t - 1] : 8'd0, t > 0 ? cb1[t - 1] : 8'd0);
        @(negedge clk);
        chk("scoreboard drained before reset", 16'(sq.size()), 16'd0);
        sq.delete();
        reset = 1'b1;
        #1;
        chk("reset c1", bus.c1, 16'd0);
        chk("reset c2", bus.c2, 16'd0);
        chk("reset c3", bus.c3, 16'd0);
        chk("reset c4", bus.c4, 16'd0);
        bus.a1 = '0;
        bus.a2 = '0;
        bus.b1 = '0;
        bus.b2 = '0;
        push4(16'd0, 16'd0, 16'd0, 16'd0);
        push4(16'd0, 16'd0, 16'd0, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (14) drive(8'd0, 8'd0, 8'd0, 8'd0);
        chk("scoreboard drained at end", 16'(sq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
